instruction_loader: RTL

//  Writer side of the 32x16 instruction memory that the processor fetch path reads.

---
 rtl/instruction_loader_pkg.sv | 16 +
 rtl/instruction_loader_if.sv | 28 ++
 rtl/instruction_loader_wrap_counter.sv | 30 +++
 rtl/instruction_loader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR
  } state_t;

  localparam int          ADDR_W_DEF = 5;
  localparam int          DATA_W_DEF = 16;
  localparam int          DEPTH      = 2 ** ADDR_W_DEF;
  localparam logic [15:0] FILL_WORD  = 16'h8000;
  localparam logic [15:0] END_MARK   = 16'hFFFF;

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - instruction-memory write/read port bundle
interface instruction_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) ();

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Loader side drives the write port and sees combinational read data
  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  // Memory side
  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/instruction_loader_wrap_counter.sv
// rtl/instruction_loader_wrap_counter.sv - up/down pointer that wraps at both ends
module wrap_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Priority clr > load > dec > inc; natural binary overflow gives the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - switch-driven writer for the 32x16 instruction memory
module instruction_loader #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] FILL_WORD = loader_pkg::FILL_WORD,
  parameter logic [DATA_W-1:0] END_MARK  = loader_pkg::END_MARK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic                 commit,
  input  logic                 prev,
  input  logic                 next,
  input  logic                 clear,
  input  logic [DATA_W-1:0]    sw_word,
  instruction_loader_if.master mem,
  output logic [DATA_W-1:0]    led_word,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic [ADDR_W:0]      word_count,
  output logic                 full,
  output logic                 done,
  output logic                 busy
);

  import loader_pkg::*;

  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              addr_inc;
  logic              addr_dec;
  logic              addr_clr;

  // Pointer moves: browse pulses only when nothing higher-priority is pending,
  // step after each write, return home once the clear sweep finishes
  always_comb begin
    addr_inc = 1'b0;
    addr_dec = 1'b0;
    addr_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (!clear && !commit) begin
          addr_dec = prev;
          addr_inc = !prev && next;
        end
      end
      S_WRITE: addr_inc = 1'b1;
      S_CLEAR: addr_clr = (clr_cnt == LAST_ADDR);
      default: ;
    endcase
  end

  wrap_counter #(
    .W(ADDR_W)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (addr_inc),
    .dec      (addr_dec),
    .load     (1'b0),
    .load_val ({ADDR_W{1'b0}}),
    .clr      (addr_clr),
    .count    (cur_addr)
  );

  // Control FSM: idle browsing/echo, single-cycle commit write, 32-cycle fill sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      wdata_q    <= '0;
      led_word   <= '0;
      word_count <= '0;
      full       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          led_word <= mem.mem_rdata;
          if (clear) begin
            clr_cnt <= '0;
            wdata_q <= FILL_WORD;
            state   <= S_CLEAR;
          end else if (commit && load_en && !full) begin
            wdata_q <= sw_word;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_count <= word_count + 1'b1;
          if ((word_count + 1'b1) == FULL_COUNT) begin
            full <= 1'b1;
          end
          if (wdata_q == END_MARK) begin
            done <= 1'b1;
          end
          state <= S_IDLE;
        end
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            word_count <= '0;
            full       <= 1'b0;
            done       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign mem.mem_we    = (state != S_IDLE);
  assign mem.mem_addr  = (state == S_CLEAR) ? clr_cnt : cur_addr;
  assign mem.mem_wdata = wdata_q;

endmodule
